qc_syndrome_check: RTL and testbench

Syndrome checker for the rate-5/6 QC-LDPC code with 4 block rows and 24 block columns. It sits directly downstream of the proto-matrix ROM and reads one circulant shift per cycle over the ROM's asynchronous address/data port. It rotates the matching Z-bit codeword block and XOR-accumulates it into the block-row syndrome. It reports the full 4·Z-bit syndrome and a pass flag (H·cᵀ = 0) to the downstream decoder/controller.

---
 rtl/ldpc_pkg.sv | 20 ++
 rtl/circ_rotate.sv | 22 ++
 rtl/qc_syndrome_check.sv | 125 ++++++++++++
 tb/tb_qc_syndrome_check.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants and types for the rate-5/6 QC-LDPC syndrome checker.
// Proto-matrix geometry and the FSM state encoding live here.
package ldpc_pkg;

  localparam int NB_COL      = 24;
  localparam int NB_ROW      = 4;
  localparam int PROTO_DEPTH = NB_ROW * NB_COL;

  // All-ones shift code marks an empty (null) circulant in the proto ROM.
  function automatic int null_shift(input int shiftw);
    return (1 << shiftw) - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/circ_rotate.sv
// Combinational Z-bit circulant rotator: out[i] = in[(i+s) mod Z].
// Shift codes at or above Z (including the null code) yield an all-zero block.
module circ_rotate #(
  parameter  int Z      = 54,
  localparam int SHIFTW = $clog2(Z)
) (
  input  logic [Z-1:0]      in_block,
  input  logic [SHIFTW-1:0] shift,
  output logic [Z-1:0]      out_block
);

  localparam logic [SHIFTW:0] Z_LIMIT = (SHIFTW + 1)'(Z);

  logic [2*Z-1:0] doubled;
  logic [Z-1:0]   shifted;

  // Right-shifting two concatenated copies gives the modular wrap for free.
  assign doubled   = {in_block, in_block};
  assign shifted   = Z'(doubled >> shift);
  assign out_block = ({1'b0, shift} < Z_LIMIT) ? shifted : '0;

endmodule

// File: rtl/qc_syndrome_check.sv
// Syndrome checker: walks the proto ROM once per codeword, rotating and
// XOR-accumulating each codeword block into its block-row syndrome.
module qc_syndrome_check
  import ldpc_pkg::*;
#(
  parameter  int Z      = 54,
  localparam int SHIFTW = $clog2(Z),
  localparam int ROM_AW = $clog2(PROTO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NB_COL*Z-1:0]  in_codeword,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [SHIFTW-1:0]    rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NB_ROW*Z-1:0]  out_syndrome,
  output logic                 out_pass
);

  localparam int ROW_W = $clog2(NB_ROW);
  localparam int COL_W = $clog2(NB_COL);

  state_t              state, state_next;
  logic [ROM_AW-1:0]   idx;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [NB_COL*Z-1:0] cw;
  logic [NB_ROW*Z-1:0] acc, acc_next;
  logic [Z-1:0]        cw_blk, rot_blk;
  logic                accept, last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (idx == ROM_AW'(PROTO_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        rom_addr = idx;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Column mux and row-targeted accumulate, driven by the row/col counters.
  always_comb begin
    cw_blk = '0;
    for (int j = 0; j < NB_COL; j++) begin
      if (col == COL_W'(j)) cw_blk = cw[j*Z +: Z];
    end
  end

  circ_rotate #(.Z(Z)) u_rotate (
    .in_block (cw_blk),
    .shift    (rom_data),
    .out_block(rot_blk)
  );

  always_comb begin
    acc_next = acc;
    for (int r = 0; r < NB_ROW; r++) begin
      if (row == ROW_W'(r)) acc_next[r*Z +: Z] = acc[r*Z +: Z] ^ rot_blk;
    end
  end

  // NOTE: the codeword holding register is pure data, loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) cw <= in_codeword;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      row          <= '0;
      col          <= '0;
      acc          <= '0;
      out_syndrome <= '0;
      out_pass     <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      row <= '0;
      col <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      if (last) begin
        idx          <= '0;
        row          <= '0;
        col          <= '0;
        out_syndrome <= acc_next;
        out_pass     <= (acc_next == '0);
      end else begin
        idx <= idx + ROM_AW'(1);
        if (col == COL_W'(NB_COL - 1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_qc_syndrome_check.sv
// Scoreboard bench for qc_syndrome_check: directed codewords against a modelled
// proto ROM; a negedge monitor pops expected results on each output handshake.
module tb_qc_syndrome_check;
  import ldpc_pkg::*;

  localparam int Z     = 54;
  localparam int CW_W  = NB_COL * Z;
  localparam int SYN_W = NB_ROW * Z;

  typedef struct {
    logic [SYN_W-1:0] syn;
    logic             pass;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CW_W-1:0]  in_codeword;
  logic [6:0]       rom_addr;
  logic [5:0]       rom_data;
  logic             out_valid;
  logic             out_ready;
  logic [SYN_W-1:0] out_syndrome;
  logic             out_pass;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic [5:0] rom_mem [PROTO_DEPTH];

  // 802.11n rate-5/6, Z=54 base matrix; -1 is a null circulant.
  int full_h [PROTO_DEPTH] = '{
    48, 29, 37, 52,  2, 16,  6, 14, 53, 31, 34,  5, 18, 42, 53, 31, 45, -1, 46, 52,  1,  0, -1, -1,
    17,  4, 30,  7, 43, 11, 24,  6, 14, 21,  6, 39, 17, 40, 47,  7, 15, 41, 19, -1, -1,  0,  0, -1,
     7,  2, 51, 31, 46, 23, 16, 11, 53, 40, 10,  7, 46, 53, 33, 35, -1, 25, 35, 38,  0, -1,  0,  0,
    19, 48, 41,  1, 10,  7, 36, 47,  5, 29, 52, 52, 31, 10, 26,  6,  3,  2, -1, 51,  1, -1, -1,  0
  };

  assign rom_data = rom_mem[rom_addr];

  qc_syndrome_check #(.Z(Z)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_codeword (in_codeword),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_syndrome(out_syndrome),
    .out_pass    (out_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [SYN_W-1:0] act, input logic [SYN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got out_valid=1 expected no result pending");
      end else begin
        e = sb_q.pop_front();
        check("sb_syndrome", out_syndrome, e.syn);
        check("sb_pass", SYN_W'(out_pass), SYN_W'(e.pass));
      end
    end
  end

  function automatic logic [Z-1:0] rotl(input logic [Z-1:0] x, input int s);
    logic [Z-1:0] r;
    for (int i = 0; i < Z; i++) r[i] = x[(i + s) % Z];
    return r;
  endfunction

  function automatic logic [SYN_W-1:0] model_syn(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] res = '0;
    int s;
    for (int r = 0; r < NB_ROW; r++) begin
      for (int c = 0; c < NB_COL; c++) begin
        s = int'(rom_mem[r*NB_COL + c]);
        if (s < Z) res[r*Z +: Z] = res[r*Z +: Z] ^ rotl(cw[c*Z +: Z], s);
      end
    end
    return res;
  endfunction

  // Dual-diagonal encoder for the full matrix: parity blocks in columns 20..23.
  function automatic logic [CW_W-1:0] encode(input logic [CW_W-1:0] info);
    logic [CW_W-1:0]  cw = info;
    logic [SYN_W-1:0] lam;
    logic [Z-1:0]     p0, p1, p2, p3;
    cw[20*Z +: 4*Z] = '0;
    lam = model_syn(cw);
    p0 = lam[0 +: Z] ^ lam[Z +: Z] ^ lam[2*Z +: Z] ^ lam[3*Z +: Z];
    p1 = lam[0 +: Z] ^ rotl(p0, 1);
    p2 = lam[Z +: Z] ^ p1;
    p3 = lam[3*Z +: Z] ^ rotl(p0, 1);
    cw[20*Z +: Z] = p0;
    cw[21*Z +: Z] = p1;
    cw[22*Z +: Z] = p2;
    cw[23*Z +: Z] = p3;
    return cw;
  endfunction

  task automatic load_null();
    for (int i = 0; i < PROTO_DEPTH; i++) rom_mem[i] = 6'(null_shift(6));
  endtask

  task automatic load_full();
    for (int i = 0; i < PROTO_DEPTH; i++) rom_mem[i] = (full_h[i] < 0) ? 6'd63 : 6'(full_h[i]);
  endtask

  task automatic push_exp(input logic [SYN_W-1:0] syn, input logic pass);
    exp_t e;
    e.syn  = syn;
    e.pass = pass;
    sb_q.push_back(e);
  endtask

  // Presents a codeword and returns #1 after its acceptance edge.
  task automatic accept_cw(input logic [CW_W-1:0] cw);
    int n = 0;
    in_valid    = 1'b1;
    in_codeword = cw;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycle number (acceptance cycle = 0) on which out_valid is first seen.
  task automatic wait_valid(output int cyc);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 200 cycles");
    end
    cyc = n + 1;
  endtask

  task automatic run_one(input string name, input logic [CW_W-1:0] cw,
                         input logic [SYN_W-1:0] syn, input logic pass);
    int c;
    push_exp(syn, pass);
    accept_cw(cw);
    wait_valid(c);
    check({name, "_valid_cycle"}, SYN_W'(c), SYN_W'(97));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [CW_W-1:0]  cw, cw_b, info, valid_cw;
    logic [SYN_W-1:0] exp_syn;
    int               c;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_codeword = '0;
    load_null();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  SYN_W'(in_ready),  SYN_W'(1));
    check("rst_out_valid", SYN_W'(out_valid), SYN_W'(0));
    check("rst_syndrome",  out_syndrome,      '0);
    check("rst_pass",      SYN_W'(out_pass),  SYN_W'(0));
    check("rst_rom_addr",  SYN_W'(rom_addr),  SYN_W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-zero codeword against the full matrix.
    load_full();
    run_one("zero_cw", '0, '0, 1'b1);

    // Single shift 3 at (0,0); shifts 60 (>=Z) and 54 (=Z) elsewhere in column 0 add nothing.
    load_null();
    rom_mem[0]          = 6'd3;
    rom_mem[1*NB_COL]   = 6'd60;
    rom_mem[3*NB_COL]   = 6'd54;
    cw    = '0;
    cw[3] = 1'b1;
    exp_syn    = '0;
    exp_syn[0] = 1'b1;
    run_one("stub_shift3", cw, exp_syn, 1'b0);

    // Wrap-around: shift 53 at (2,5), block 5 bit 0 lands on row 2 bit 1.
    load_null();
    rom_mem[2*NB_COL + 5] = 6'd53;
    cw           = '0;
    cw[5*Z]      = 1'b1;
    exp_syn      = '0;
    exp_syn[2*Z+1] = 1'b1;
    run_one("stub_wrap", cw, exp_syn, 1'b0);

    // Golden codeword passes; one flipped bit fails with the modelled syndrome.
    load_full();
    for (int i = 0; i < CW_W; i++) info[i] = 1'($urandom_range(0, 1));
    valid_cw = encode(info);
    run_one("golden_valid", valid_cw, '0, 1'b1);
    cw       = valid_cw;
    cw[700]  = ~cw[700];
    run_one("golden_flip700", cw, model_syn(cw), 1'b0);
    run_one("random_info", info, model_syn(info), model_syn(info) == '0);

    // Backpressure in DONE, with a second codeword held on in_valid meanwhile.
    load_null();
    rom_mem[2*NB_COL + 5] = 6'd53;
    cw             = '0;
    cw[5*Z]        = 1'b1;
    exp_syn        = '0;
    exp_syn[2*Z+1] = 1'b1;
    out_ready = 1'b0;
    push_exp(exp_syn, 1'b0);
    accept_cw(cw);
    wait_valid(c);
    check("bp_valid_cycle", SYN_W'(c), SYN_W'(97));
    cw_b          = '0;
    cw_b[5*Z+10]  = 1'b1;
    in_valid      = 1'b1;
    in_codeword   = cw_b;
    exp_syn        = '0;
    exp_syn[2*Z+11] = 1'b1;
    push_exp(exp_syn, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", SYN_W'(out_valid), SYN_W'(1));
      check("bp_syndrome",  out_syndrome,      SYN_W'(1) << (2*Z+1));
      check("bp_pass",      SYN_W'(out_pass),  SYN_W'(0));
      check("bp_in_ready",  SYN_W'(in_ready),  SYN_W'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bubble_in_ready",  SYN_W'(in_ready),  SYN_W'(1));
    check("bubble_out_valid", SYN_W'(out_valid), SYN_W'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("second_accepted", SYN_W'(in_ready), SYN_W'(0));
    wait_valid(c);
    check("second_valid_cycle", SYN_W'(c), SYN_W'(97));
    @(posedge clk);
    #1;

    // Reset at idx=40 discards the operation; a new codeword then completes.
    load_full();
    accept_cw(info);
    repeat (40) @(posedge clk);
    #1;
    check("mid_run_rom_addr", SYN_W'(rom_addr), SYN_W'(40));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready",  SYN_W'(in_ready),  SYN_W'(1));
    check("mid_rst_out_valid", SYN_W'(out_valid), SYN_W'(0));
    check("mid_rst_rom_addr",  SYN_W'(rom_addr),  SYN_W'(0));
    repeat (110) @(posedge clk);
    #1;
    check("mid_rst_no_result", SYN_W'(out_valid), SYN_W'(0));
    run_one("after_reset", valid_cw, '0, 1'b1);

    check("sb_drained", SYN_W'(sb_q.size()), SYN_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
